fpu_mul_exception_resolver: RTL and testbench
=============================================

// Module: fpu_mul_exception_resolver
// PURPOSE
// - Consumer side of the multiplier exception-flag interface: takes the raw product word plus
//   invalid_flag / overflow_flag / initial_zero_flag and emits the final IEEE-754 single result.
// - Substitutes special values, accumulates sticky status flags, counts exceptional results.
// - Sits between the multiplier rounding/exception stage and the FPU writeback; 2-stage
//   valid/ready pipeline.
// PARAMETERS
// - CNT_W    8    width of the saturating exceptional-result counter
// PORTS
// - clk             in   1   clock, rising edge
// - rst             in   1   asynchronous, active-high reset
// - in_valid        in   1   product + flags valid
// - in_ready        out  1   resolver can accept input this cycle
// - in_sign         in   1   product sign
// - in_exp          in   8   product biased exponent
// - in_mant         in   23  product fraction
// - invalid_flag    in   1   from exception detector
// - overflow_flag   in   1   from exception detector
// - initial_zero_flag in 1   from exception detector
// - out_valid       out  1   result valid
// - out_ready       in   1   writeback accepts result
// - out_result      out  32  final IEEE-754 word
// - out_exc         out  3   {invalid, overflow, zero} applied to out_result
// - flag_clear      in   1   clear sticky flags and counter
// - sticky_flags    out  3   {invalid, overflow, zero} accumulated since last clear
// - exc_count       out  CNT_W  saturating count of results with any out_exc bit set
// BEHAVIOUR
// - Reset: s1/s2 valid = 0, out_valid = 0, out_result = 0, out_exc = 0, sticky_flags = 0,
//   exc_count = 0; in_ready = 1 as soon as rst deasserts.
// - Reset mid-operation: all in-flight entries discarded, no flags/counter update.
// - Stage 1 (capture): on in_valid && in_ready register sign/exp/mant and flags.
// - Stage 2 (resolve): registered output; priority invalid > overflow > zero > pass:
//   invalid  -> 32'h7FC0_0000 (canonical qNaN, sign forced 0), out_exc = 3'b100
//   overflow -> {sign, 8'hFF, 23'h0}, out_exc = 3'b010
//   zero     -> {sign, 31'h0}, out_exc = 3'b001
//   none     -> {sign, exp, mant}, out_exc = 3'b000
// - Exactly one out_exc bit set for any exceptional result, even if several flags are raised.
// - Latency: 2 cycles, in_valid accept to out_valid, when out_ready held high.
// - Throughput: 1 result/cycle.
// - Handshake: each stage loads when empty or its downstream stage advances.
//   in_ready = !s1_valid || (!out_valid || out_ready) -- combinational, no bubble.
//   out_result / out_exc stay stable while out_valid && !out_ready.
//   No input dropped; no output duplicated; full pipeline (2 entries) stalls with in_ready = 0.
// - Sticky/counter update only on output handshake (out_valid && out_ready):
//   sticky_flags |= out_exc; exc_count += |out_exc, saturating at all-ones.
// - flag_clear: clears sticky_flags and exc_count next edge.
//   If flag_clear coincides with an accepted exceptional result: result's bits/count survive
//   (sticky = out_exc, count = 1); set wins over clear.
// CONFIGURATION
// - FPU_EXC_IRQ_EN defined:
//   adds input irq_mask[2:0] and output irq (registered, reset 0).
//   irq = |(next sticky_flags & irq_mask), updated every cycle, clears one cycle after flag_clear.
// - FPU_EXC_IRQ_EN undefined: irq_mask/irq ports and logic absent; all else identical.
// TESTING
// - Normal 0x3FC0_0000 (1.5), no flags, out_ready=1 -> out_result 0x3FC0_0000 two cycles later,
//   out_exc 0, sticky 0.
// - invalid_flag + overflow_flag, sign=1 -> out_result 0x7FC0_0000, out_exc 3'b100,
//   sticky 3'b100, exc_count 1.
// - Back-to-back: overflow (sign 0), then zero (sign 1), out_ready=0 for 3 cycles
//   -> in_ready=0 after 2 accepts; on release 0x7F80_0000 then 0x8000_0000 in order;
//   sticky 3'b011.
// - flag_clear on same cycle as accepted zero result -> sticky 3'b001, exc_count 1; next
//   flag_clear alone -> both 0.
// - CNT_W=2: 5 accepted invalid results -> exc_count saturates at 3.
// - rst asserted with 2 entries in flight -> out_valid 0 immediately, sticky/count 0, no
//   result emitted after release.
// - FPU_EXC_IRQ_EN, irq_mask=3'b010: overflow result accepted -> irq=1; flag_clear -> irq=0.

Source files
------------

// File: rtl/fpu_mul_exception_resolver.sv
// Final exception resolution for the FP multiplier: substitutes special values, keeps sticky flags
// and a saturating exception counter. Optional interrupt output under macro FPU_EXC_IRQ_EN.
module fpu_mul_exception_resolver #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [7:0]       in_exp,
    input  logic [22:0]      in_mant,
    input  logic             invalid_flag,
    input  logic             overflow_flag,
    input  logic             initial_zero_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [2:0]       out_exc,
    input  logic             flag_clear,
    output logic [2:0]       sticky_flags,
    output logic [CNT_W-1:0] exc_count
`ifdef FPU_EXC_IRQ_EN
    ,
    input  logic [2:0]       irq_mask,
    output logic             irq
`endif
);

    localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

    // Priority invalid > overflow > zero guarantees a one-hot exception code.
    function automatic logic [34:0] resolve(input logic sign, input logic [7:0] exp,
                                            input logic [22:0] mant, input logic [2:0] flags);
        logic [34:0] r;
        if (flags[2])
            r = {3'b100, CANON_QNAN};
        else if (flags[1])
            r = {3'b010, sign, 8'hFF, 23'h0};
        else if (flags[0])
            r = {3'b001, sign, 31'h0};
        else
            r = {3'b000, sign, exp, mant};
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        logic [CNT_W-1:0] r;
        if (inc && (v != {CNT_W{1'b1}}))
            r = v + CNT_W'(1);
        else
            r = v;
        return r;
    endfunction

    logic        vld_p1;
    logic        sign_p1;
    logic [7:0]  exp_p1;
    logic [22:0] mant_p1;
    logic [2:0]  flags_p1;

    logic        adv_p2;
    logic        take_p1;
    logic        load_p2;
    logic        handshake;
    logic [34:0] resolved_p1;
    logic [2:0]  sticky_next;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        adv_p2      = !out_valid || out_ready;
        in_ready    = !vld_p1 || adv_p2;
        take_p1     = in_valid && in_ready;
        load_p2     = vld_p1 && adv_p2;
        handshake   = out_valid && out_ready;
        resolved_p1 = resolve(sign_p1, exp_p1, mant_p1, flags_p1);
    end

    // Stage 1: capture product and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= take_p1 || (vld_p1 && !adv_p2);
    end

    always_ff @(posedge clk) begin
        if (take_p1) begin
            sign_p1  <= in_sign;
            exp_p1   <= in_exp;
            mant_p1  <= in_mant;
            flags_p1 <= {invalid_flag, overflow_flag, initial_zero_flag};
        end
    end

    // Stage 2: resolved result register, held while writeback stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= 32'h0;
            out_exc    <= 3'b000;
        end else begin
            if (adv_p2)
                out_valid <= vld_p1;
            if (load_p2) begin
                out_result <= resolved_p1[31:0];
                out_exc    <= resolved_p1[34:32];
            end
        end
    end

    // Status: a result retiring in the same cycle as a clear survives the clear
    always_comb begin
        sticky_next = flag_clear ? 3'b000 : sticky_flags;
        count_next  = flag_clear ? '0 : exc_count;
        if (handshake)
            sticky_next = sticky_next | out_exc;
        count_next = sat_inc(count_next, handshake && (|out_exc));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= 3'b000;
            exc_count    <= '0;
        end else begin
            sticky_flags <= sticky_next;
            exc_count    <= count_next;
        end
    end

`ifdef FPU_EXC_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            irq <= 1'b0;
        else
            irq <= |(sticky_next & irq_mask);
    end
`endif

endmodule

// File: tb/tb_fpu_mul_exception_resolver.sv
// Scoreboard bench for fpu_mul_exception_resolver; exercises the FPU_EXC_IRQ_EN path when defined.
module tb_fpu_mul_exception_resolver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready, in_ready2;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'h0;
    logic [22:0] in_mant = 23'h0;
    logic        invalid_flag = 1'b0;
    logic        overflow_flag = 1'b0;
    logic        initial_zero_flag = 1'b0;
    logic        out_valid, out_valid2;
    logic        out_ready = 1'b0;
    logic [31:0] out_result, out_result2;
    logic [2:0]  out_exc, out_exc2;
    logic        flag_clear = 1'b0;
    logic [2:0]  sticky_flags, sticky_flags2;
    logic [7:0]  exc_count;
    logic [1:0]  exc_count2;
`ifdef FPU_EXC_IRQ_EN
    logic [2:0]  irq_mask = 3'b000;
    logic        irq, irq2;
`endif

    int total = 0;
    int bad = 0;
    int n_out = 0;
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    fpu_mul_exception_resolver #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .invalid_flag(invalid_flag), .overflow_flag(overflow_flag),
        .initial_zero_flag(initial_zero_flag), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_exc(out_exc), .flag_clear(flag_clear),
        .sticky_flags(sticky_flags), .exc_count(exc_count)
`ifdef FPU_EXC_IRQ_EN
        , .irq_mask(irq_mask), .irq(irq)
`endif
    );

    fpu_mul_exception_resolver #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .invalid_flag(invalid_flag), .overflow_flag(overflow_flag),
        .initial_zero_flag(initial_zero_flag), .out_valid(out_valid2), .out_ready(out_ready),
        .out_result(out_result2), .out_exc(out_exc2), .flag_clear(flag_clear),
        .sticky_flags(sticky_flags2), .exc_count(exc_count2)
`ifdef FPU_EXC_IRQ_EN
        , .irq_mask(irq_mask), .irq(irq2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [22:0] m,
                        input logic [2:0] f, input logic [31:0] er, input logic [2:0] ee);
        bit ok;
        ok = 1'b0;
        in_sign = s;
        in_exp = e;
        in_mant = m;
        {invalid_flag, overflow_flag, initial_zero_flag} = f;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end else begin
            exp_q.push_back({ee, er});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        {invalid_flag, overflow_flag, initial_zero_flag} = 3'b000;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        flag_clear = 1'b1;
        @(posedge clk);
        #1;
        flag_clear = 1'b0;
    endtask

    // Monitor: every output handshake must match the oldest outstanding expectation
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output actual=%h required=none", out_result);
                end else begin
                    e = exp_q.pop_front();
                    check("out_result", out_result, e[31:0]);
                    check("out_exc", {29'h0, out_exc}, {29'h0, e[34:32]});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n_before;

        // reset state
        cycles(2);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_exc", {29'h0, out_exc}, 32'h0);
        check("rst_sticky", {29'h0, sticky_flags}, 32'h0);
        check("rst_count", {24'h0, exc_count}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        out_ready = 1'b1;
        cycles(1);

        // normal 1.5 with latency
        send(1'b0, 8'h7F, 23'h40_0000, 3'b000, 32'h3FC0_0000, 3'b000);
        check("lat_not_early", {31'h0, out_valid}, 32'h0);
        cycles(1);
        check("lat_valid", {31'h0, out_valid}, 32'h1);
        cycles(2);
        check("normal_sticky", {29'h0, sticky_flags}, 32'h0);
        check("normal_count", {24'h0, exc_count}, 32'h0);

        // invalid + overflow, negative sign
        send(1'b1, 8'hFF, 23'h12_3456, 3'b110, 32'h7FC0_0000, 3'b100);
        cycles(3);
        check("inv_sticky", {29'h0, sticky_flags}, 32'h4);
        check("inv_count", {24'h0, exc_count}, 32'h1);
        pulse_clear();
        check("clr_sticky", {29'h0, sticky_flags}, 32'h0);
        check("clr_count", {24'h0, exc_count}, 32'h0);

        // back-to-back with stalled writeback
        out_ready = 1'b0;
        send(1'b0, 8'hFE, 23'h00_0005, 3'b010, 32'h7F80_0000, 3'b010);
        send(1'b1, 8'h01, 23'h00_0001, 3'b001, 32'h8000_0000, 3'b001);
        check("full_in_ready", {31'h0, in_ready}, 32'h0);
        check("stall_valid", {31'h0, out_valid}, 32'h1);
        check("stall_result", out_result, 32'h7F80_0000);
        cycles(1);
        check("stall_result_hold", out_result, 32'h7F80_0000);
        check("stall_in_ready_hold", {31'h0, in_ready}, 32'h0);
        cycles(1);
        out_ready = 1'b1;
        cycles(4);
        check("b2b_drained", {31'h0, out_valid}, 32'h0);
        check("b2b_sticky", {29'h0, sticky_flags}, 32'h3);
        check("b2b_count", {24'h0, exc_count}, 32'h2);

        // clear coinciding with a retiring zero result
        send(1'b0, 8'h00, 23'h00_0000, 3'b001, 32'h0000_0000, 3'b001);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("coinc_out_seen", {31'h0, seen}, 32'h1);
        pulse_clear();
        check("coinc_sticky", {29'h0, sticky_flags}, 32'h1);
        check("coinc_count", {24'h0, exc_count}, 32'h1);
        pulse_clear();
        check("clr2_sticky", {29'h0, sticky_flags}, 32'h0);
        check("clr2_count", {24'h0, exc_count}, 32'h0);

        // saturation of the narrow counter
        for (int k = 0; k < 5; k++)
            send(k[0], 8'h80, 23'h7F_FFFF, 3'b100, 32'h7FC0_0000, 3'b100);
        cycles(4);
        check("sat_count8", {24'h0, exc_count}, 32'h5);
        check("sat_count2", {30'h0, exc_count2}, 32'h3);
        check("sat_sticky", {29'h0, sticky_flags}, 32'h4);

`ifdef FPU_EXC_IRQ_EN
        irq_mask = 3'b010;
        cycles(1);
        check("irq_masked_off", {31'h0, irq}, 32'h0);
        send(1'b1, 8'hFF, 23'h0, 3'b010, 32'hFF80_0000, 3'b010);
        cycles(3);
        check("irq_set", {31'h0, irq}, 32'h1);
        pulse_clear();
        check("irq_cleared", {31'h0, irq}, 32'h0);
        // leave status nonzero so the reset check below is meaningful
        send(1'b0, 8'h00, 23'h0, 3'b001, 32'h0000_0000, 3'b001);
        cycles(3);
`endif

        // reset with two entries in flight
        out_ready = 1'b0;
        send(1'b0, 8'h80, 23'h00_0000, 3'b000, 32'h4000_0000, 3'b000);
        send(1'b0, 8'h80, 23'h00_0000, 3'b100, 32'h7FC0_0000, 3'b100);
        check("pre_rst_full", {31'h0, in_ready}, 32'h0);
        #2;
        rst = 1'b1;
        exp_q.delete();
        n_before = n_out;
        #1;
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_sticky", {29'h0, sticky_flags}, 32'h0);
        check("midrst_count", {24'h0, exc_count}, 32'h0);
        check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        cycles(2);
        rst = 1'b0;
        out_ready = 1'b1;
        cycles(5);
        check("post_rst_no_output", n_out, n_before);
        check("post_rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("post_rst_count", {24'h0, exc_count}, 32'h0);

        check("queue_empty", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
